// File: rtl/issueque_int_if.sv
// issueque_int_if: dispatch, CDB and issue handshake signals of the integer issue queue
interface issueque_int_if #(parameter int W_TAG = 6);
  logic             dispatch_en;
  logic             dispatch_ready;
  logic [5:0]       dispatch_opcode;
  logic [15:0]      dispatch_imm;
  logic [W_TAG-1:0] dispatch_rdtag;
  logic [W_TAG-1:0] dispatch_rstag;
  logic [W_TAG-1:0] dispatch_rttag;
  logic [31:0]      dispatch_rsdata;
  logic [31:0]      dispatch_rtdata;
  logic             dispatch_rsvalid;
  logic             dispatch_rtvalid;
  logic [W_TAG-1:0] cdb_tag;
  logic             cdb_valid;
  logic [31:0]      cdb_data;
  logic             issue_valid;
  logic             issue_ready;
  logic [5:0]       issue_opcode;
  logic [15:0]      issue_imm;
  logic [W_TAG-1:0] issue_rdtag;
  logic [31:0]      issue_rsdata;
  logic [31:0]      issue_rtdata;
  modport master (
    output dispatch_en, dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
           cdb_tag, cdb_valid, cdb_data, issue_ready,
    input  dispatch_ready, issue_valid, issue_opcode, issue_imm, issue_rdtag, issue_rsdata, issue_rtdata
  );
  modport slave (
    input  dispatch_en, dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
           cdb_tag, cdb_valid, cdb_data, issue_ready,
    output dispatch_ready, issue_valid, issue_opcode, issue_imm, issue_rdtag, issue_rsdata, issue_rtdata
  );
endinterface

// File: rtl/issueque_int.sv
// issueque_int: age-ordered integer issue queue with CDB snoop and oldest-ready-first issue
module issueque_int #(
  parameter int DEPTH = 4,
  parameter int W_TAG = 6
) (
  input logic           clk,
  input logic           reset,
  issueque_int_if.slave io
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic             valid;
    logic [5:0]       opcode;
    logic [15:0]      imm;
    logic [W_TAG-1:0] rdtag;
    logic [W_TAG-1:0] rstag;
    logic [W_TAG-1:0] rttag;
    logic [31:0]      rsdata;
    logic [31:0]      rtdata;
    logic             rsvalid;
    logic             rtvalid;
  } entry_t;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           shf [DEPTH];
  entry_t           new_e;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0]    sel;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    wr_idx;
  logic             do_issue;
  logic             do_disp;
  // readiness per entry and occupancy (valid entries form a contiguous prefix)
  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = ent_q[k].valid & ent_q[k].rsvalid & ent_q[k].rtvalid;
      cnt = cnt + CW'(ent_q[k].valid);
    end
  end
  // oldest ready entry wins: scan from the top so the lowest index is kept last
  always_comb begin
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) if (rdy[k]) sel = IW'(k);
  end
  assign io.issue_valid    = |rdy;
  assign do_issue          = io.issue_valid & io.issue_ready;
  assign io.dispatch_ready = ~ent_q[DEPTH-1].valid;
  assign do_disp           = io.dispatch_en & io.dispatch_ready;
  assign wr_idx            = cnt - CW'(do_issue);
  assign io.issue_opcode   = io.issue_valid ? ent_q[sel].opcode : '0;
  assign io.issue_imm      = io.issue_valid ? ent_q[sel].imm    : '0;
  assign io.issue_rdtag    = io.issue_valid ? ent_q[sel].rdtag  : '0;
  assign io.issue_rsdata   = io.issue_valid ? ent_q[sel].rsdata : '0;
  assign io.issue_rtdata   = io.issue_valid ? ent_q[sel].rtdata : '0;
  assign new_e = '{valid: 1'b1, opcode: io.dispatch_opcode, imm: io.dispatch_imm,
                   rdtag: io.dispatch_rdtag, rstag: io.dispatch_rstag, rttag: io.dispatch_rttag,
                   rsdata: io.dispatch_rsdata, rtdata: io.dispatch_rtdata,
                   rsvalid: io.dispatch_rsvalid, rtvalid: io.dispatch_rtvalid};
  // compact out the issued entry, snoop the CDB at the new position, then append the dispatch unsnooped
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) shf[k] = ent_q[k+1];
    shf[DEPTH-1] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      ent_d[j] = (do_issue && j >= int'(sel)) ? shf[j] : ent_q[j];
      if (io.cdb_valid && ent_d[j].valid && !ent_d[j].rsvalid && ent_d[j].rstag == io.cdb_tag) begin
        ent_d[j].rsdata  = io.cdb_data;
        ent_d[j].rsvalid = 1'b1;
      end
      if (io.cdb_valid && ent_d[j].valid && !ent_d[j].rtvalid && ent_d[j].rttag == io.cdb_tag) begin
        ent_d[j].rtdata  = io.cdb_data;
        ent_d[j].rtvalid = 1'b1;
      end
      if (do_disp && CW'(j) == wr_idx) ent_d[j] = new_e;
    end
  end
  // entry storage; asynchronous clear drops every resident entry at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
    else for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
  end
endmodule

// File: tb/tb_issueque_int.sv
// tb_issueque_int: scoreboard bench with a queue-based reference model of the issue queue
module tb_issueque_int;
  localparam int DEPTH = 4;
  localparam int W_TAG = 6;
  typedef struct {
    logic [5:0]  op;
    logic [15:0] imm;
    logic [5:0]  rd, rs, rt;
    logic [31:0] rsd, rtd;
    bit          rsv, rtv;
  } ment_t;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int failures = 0;
  ment_t mq[$];
  logic [91:0] expq[$];
  bit m_iss = 0, m_acc = 0, m_cv = 0;
  int m_idx = -1;
  ment_t m_new;
  logic [5:0] m_ct = '0;
  logic [31:0] m_cd = '0;
  issueque_int_if #(.W_TAG(W_TAG)) io();
  issueque_int #(.DEPTH(DEPTH), .W_TAG(W_TAG)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [91:0] a, input logic [91:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    io.dispatch_en = 0;
    io.cdb_valid = 0;
  endtask
  task automatic disp(input logic [5:0] op, input logic [15:0] imm, input logic [5:0] rd, input logic [5:0] rs,
                      input logic [5:0] rt, input logic [31:0] rsd, input logic [31:0] rtd, input logic rsv, input logic rtv);
    io.dispatch_en = 1;
    io.dispatch_opcode = op;
    io.dispatch_imm = imm;
    io.dispatch_rdtag = rd;
    io.dispatch_rstag = rs;
    io.dispatch_rttag = rt;
    io.dispatch_rsdata = rsd;
    io.dispatch_rtdata = rtd;
    io.dispatch_rsvalid = rsv;
    io.dispatch_rtvalid = rtv;
  endtask
  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    io.cdb_valid = 1;
    io.cdb_tag = t;
    io.cdb_data = d;
  endtask
  // reference model: apply last cycle's decisions at the edge, then predict this cycle
  initial begin
    forever begin
      @(posedge clk);
      if (m_iss) mq.delete(m_idx);
      if (m_cv) foreach (mq[i]) begin
        if (!mq[i].rsv && mq[i].rs == m_ct) begin mq[i].rsd = m_cd; mq[i].rsv = 1; end
        if (!mq[i].rtv && mq[i].rt == m_ct) begin mq[i].rtd = m_cd; mq[i].rtv = 1; end
      end
      if (m_acc) mq.push_back(m_new);
      #3;
      m_iss = 0;
      m_acc = 0;
      m_cv = 0;
      if (!reset) mq.delete();
      else begin
        m_idx = -1;
        foreach (mq[i]) if (m_idx < 0 && mq[i].rsv && mq[i].rtv) m_idx = i;
        check("dispatch_ready", io.dispatch_ready, mq.size() < DEPTH);
        check("issue_valid", io.issue_valid, m_idx >= 0);
        m_iss = (m_idx >= 0) && io.issue_ready;
        if (m_iss) expq.push_back({mq[m_idx].op, mq[m_idx].imm, mq[m_idx].rd, mq[m_idx].rsd, mq[m_idx].rtd});
        m_acc = io.dispatch_en && (mq.size() < DEPTH);
        m_new = '{io.dispatch_opcode, io.dispatch_imm, io.dispatch_rdtag, io.dispatch_rstag, io.dispatch_rttag,
                  io.dispatch_rsdata, io.dispatch_rtdata, io.dispatch_rsvalid, io.dispatch_rtvalid};
        m_cv = io.cdb_valid;
        m_ct = io.cdb_tag;
        m_cd = io.cdb_data;
      end
    end
  end
  // monitor: every DUT handshake pops and compares one expected issue
  initial begin
    logic [91:0] got;
    bit hs;
    forever begin
      @(negedge clk);
      hs = io.issue_valid && io.issue_ready;
      got = {io.issue_opcode, io.issue_imm, io.issue_rdtag, io.issue_rsdata, io.issue_rtdata};
      check("issue_handshake", hs, expq.size() > 0);
      if (hs && expq.size() > 0) check("issue_fields", got, expq.pop_front());
      else expq.delete();
      if (!io.issue_valid) check("idle_data_zero", got, '0);
    end
  end
  initial begin
    io.issue_ready = 0;
    io.cdb_tag = '0;
    io.cdb_data = '0;
    disp('0, '0, '0, '0, '0, '0, '0, 0, 0);
    idle();
    repeat (2) tick();
    reset = 1;
    repeat (2) tick();
    disp(6'h20, 16'h0, 6'd5, 6'd0, 6'd0, 32'd3, 32'd4, 1, 1);
    io.issue_ready = 1;
    tick(); idle(); repeat (2) tick();
    disp(6'h21, 16'h1, 6'd7, 6'd9, 6'd0, 32'h0, 32'h11, 0, 1);
    tick();
    disp(6'h22, 16'h2, 6'd8, 6'd1, 6'd2, 32'ha, 32'hb, 1, 1);
    tick(); idle(); tick();
    cdb(6'd9, 32'h55);
    tick(); idle(); repeat (2) tick();
    for (int i = 1; i <= 4; i++) begin
      disp(6'h23, 16'(i), 6'(i + 10), 6'(i), 6'd0, 32'h0, 32'(i * 100), 0, 1);
      tick();
    end
    disp(6'h24, 16'h5, 6'd15, 6'd0, 6'd0, 32'h5, 32'h6, 1, 1);
    cdb(6'd2, 32'h2222);
    tick();
    io.cdb_valid = 0;
    repeat (2) tick();
    idle();
    for (int t = 1; t <= 4; t++) begin cdb(6'(t), 32'(t * 16'h1111)); tick(); end
    idle(); repeat (3) tick();
    disp(6'h25, 16'h10, 6'd30, 6'd10, 6'd0, 32'h0, 32'h1, 0, 1); tick();
    disp(6'h26, 16'h11, 6'd31, 6'd11, 6'd0, 32'h0, 32'h2, 0, 1); tick();
    disp(6'h27, 16'h12, 6'd32, 6'd3, 6'd0, 32'h0, 32'h3, 0, 1); tick();
    disp(6'h28, 16'h13, 6'd33, 6'd12, 6'd0, 32'h0, 32'h4, 0, 1); tick();
    idle(); cdb(6'd10, 32'h1010); tick();
    cdb(6'd3, 32'h3333);
    disp(6'h29, 16'h14, 6'd34, 6'd0, 6'd0, 32'h7, 32'h8, 1, 1);
    tick(); idle(); tick();
    cdb(6'd11, 32'h1111); tick();
    cdb(6'd12, 32'h1212); tick();
    idle(); repeat (3) tick();
    io.issue_ready = 0;
    disp(6'h2a, 16'h20, 6'd40, 6'd20, 6'd0, 32'h0, 32'h1, 0, 1); tick();
    disp(6'h2b, 16'h21, 6'd41, 6'd21, 6'd0, 32'h0, 32'h2, 0, 1); tick();
    disp(6'h2c, 16'h22, 6'd42, 6'd0, 6'd0, 32'h9, 32'ha, 1, 1); tick();
    idle(); tick();
    reset = 0;
    #1;
    check("reset_issue_valid", io.issue_valid, 1'b0);
    check("reset_dispatch_ready", io.dispatch_ready, 1'b1);
    tick();
    reset = 1;
    io.issue_ready = 1;
    cdb(6'd20, 32'h2020);
    tick(); idle(); repeat (3) tick();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1)
        disp(6'($urandom), 16'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
             $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else io.dispatch_en = 0;
      if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
      else io.cdb_valid = 0;
      io.issue_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    io.issue_ready = 1;
    for (int t = 0; t < 8; t++) begin cdb(6'(t), 32'(t)); tick(); end
    idle(); repeat (6) tick();
    check("scoreboard_drained", 92'(expq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
